// File: rtl/shreg_rs.sv
// shreg_rs - WIDTH-bit universal register with async reset, sync clear/set,
// enable-gated load, shift and rotate, plus serial in/out on both ends.
//
// Optional feature (macro SHREG_RS_COUNT_EN): modes 110/111 increment and
// decrement q, and a registered carry/borrow flag co is exposed. Without the
// macro, modes 110/111 hold q, port co is absent and no adder is built.
//
// Ports:
//   clk   in   rising-edge clock
//   r     in   async active-high reset, q = RESET_VALUE while high
//   c     in   sync clear (highest sync priority), q <= 0
//   s     in   sync set, q <= SET_VALUE
//   e     in   enable for mode operations
//   mode  in   [2:0] 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror,
//              110 inc / 111 dec (count build) else hold
//   d     in   [WIDTH-1:0] parallel load data
//   sil   in   serial bit entering q[0] on shift-left
//   sir   in   serial bit entering q[WIDTH-1] on shift-right
//   q     out  [WIDTH-1:0] register contents
//   som   out  q[WIDTH-1]
//   sol   out  q[0]
//   co    out  carry/borrow flag (count build only)

// Per-bit next-state mux. Neighbour bits are resolved by the parent so the
// cell never needs to know where it sits in the word.
module shreg_rs_cell (
  input  logic       i_q,      // current value of this bit
  input  logic       i_c,
  input  logic       i_s,
  input  logic       i_set,    // this bit of SET_VALUE
  input  logic       i_e,
  input  logic [2:0] i_mode,
  input  logic       i_d,
  input  logic       i_shl,    // bit arriving on shift-left
  input  logic       i_rol,    // bit arriving on rotate-left
  input  logic       i_shr,    // bit arriving on shift-right
  input  logic       i_ror,    // bit arriving on rotate-right
`ifdef SHREG_RS_COUNT_EN
  input  logic       i_inc,    // this bit of q+1
  input  logic       i_dec,    // this bit of q-1
`endif
  output logic       o_nxt
);
  always_comb begin
    o_nxt = i_q;
    if (i_c)      o_nxt = 1'b0;
    else if (i_s) o_nxt = i_set;
    else if (i_e) begin
      case (i_mode)
        3'b001:  o_nxt = i_d;
        3'b010:  o_nxt = i_shl;
        3'b011:  o_nxt = i_shr;
        3'b100:  o_nxt = i_rol;
        3'b101:  o_nxt = i_ror;
`ifdef SHREG_RS_COUNT_EN
        3'b110:  o_nxt = i_inc;
        3'b111:  o_nxt = i_dec;
`endif
        default: o_nxt = i_q;
      endcase
    end
  end
endmodule

module shreg_rs #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             r,
  input  logic             c,
  input  logic             s,
  input  logic             e,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q,
  output logic             som,
  output logic             sol
`ifdef SHREG_RS_COUNT_EN
  ,
  output logic             co
`endif
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

`ifdef SHREG_RS_COUNT_EN
  logic             r_co;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_cnt;     // counting edge: enabled, no clear/set, mode 11x
  logic             w_wrap;    // carry out of inc or borrow out of dec

  assign w_inc  = r_q + WIDTH'(1);
  assign w_dec  = r_q - WIDTH'(1);
  assign w_cnt  = e & ~c & ~s & (mode[2:1] == 2'b11);
  assign w_wrap = mode[0] ? ~|r_q : &r_q;
`endif

  // Edge bits are wired per position inside generate-ifs, so WIDTH=1 never
  // produces an out-of-range or negative select; rotates degenerate to hold.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_lo_sh, w_lo_rot, w_hi_sh, w_hi_rot;

    if (i == 0) begin : g_lo_edge
      assign w_lo_sh  = sil;
      assign w_lo_rot = r_q[WIDTH-1];
    end else begin : g_lo_mid
      assign w_lo_sh  = r_q[i-1];
      assign w_lo_rot = r_q[i-1];
    end

    if (i == WIDTH-1) begin : g_hi_edge
      assign w_hi_sh  = sir;
      assign w_hi_rot = r_q[0];
    end else begin : g_hi_mid
      assign w_hi_sh  = r_q[i+1];
      assign w_hi_rot = r_q[i+1];
    end

    shreg_rs_cell u_cell (
      .i_q    (r_q[i]),
      .i_c    (c),
      .i_s    (s),
      .i_set  (SET_VALUE[i]),
      .i_e    (e),
      .i_mode (mode),
      .i_d    (d[i]),
      .i_shl  (w_lo_sh),
      .i_rol  (w_lo_rot),
      .i_shr  (w_hi_sh),
      .i_ror  (w_hi_rot),
`ifdef SHREG_RS_COUNT_EN
      .i_inc  (w_inc[i]),
      .i_dec  (w_dec[i]),
`endif
      .o_nxt  (w_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) r_q <= RESET_VALUE;
    else   r_q <= w_nxt;
  end

`ifdef SHREG_RS_COUNT_EN
  // co only moves on counting edges; clear/set/reset zero it.
  always_ff @(posedge clk or posedge r) begin
    if (r)             r_co <= 1'b0;
    else if (c | s)    r_co <= 1'b0;
    else if (w_cnt)    r_co <= w_wrap;
  end
  assign co = r_co;
`endif

  assign q   = r_q;
  assign som = r_q[WIDTH-1];
  assign sol = r_q[0];
endmodule

// File: tb/tb_shreg_rs.sv
module tb_shreg_rs;
  logic       clk = 1'b0;
  logic       r = 1'b0, c = 1'b0, s = 1'b0, e = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       sil = 1'b0, sir = 1'b0;
  logic [7:0] q;
  logic       som, sol;
`ifdef SHREG_RS_COUNT_EN
  logic       co;
`endif

  int npass = 0;
  int ntot  = 0;

  // reference state
  logic [7:0] mq;
  logic       mco;

  shreg_rs #(.WIDTH(8)) dut (
    .clk(clk), .r(r), .c(c), .s(s), .e(e), .mode(mode), .d(d),
    .sil(sil), .sir(sir), .q(q), .som(som), .sol(sol)
`ifdef SHREG_RS_COUNT_EN
    , .co(co)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c, s, e;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil, sir;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ic, is, ie, input logic [2:0] im,
                       input logic [7:0] id, input logic isl, isr);
    c = ic; s = is; e = ie; mode = im; d = id; sil = isl; sir = isr;
  endtask

  // Reference: next q from the behavioural rules, plain arithmetic on a byte.
  task automatic model_edge();
    logic [7:0] n;
    n = mq;
    if (c) begin n = 8'h00; mco = 1'b0; end
    else if (s) begin n = 8'hFF; mco = 1'b0; end
    else if (e) begin
      case (mode)
        3'd1: n = d;
        3'd2: n = 8'((mq << 1) | 8'(sil));
        3'd3: n = 8'((mq >> 1) | (8'(sir) << 7));
        3'd4: n = 8'((mq << 1) | (mq >> 7));
        3'd5: n = 8'((mq >> 1) | (mq << 7));
`ifdef SHREG_RS_COUNT_EN
        3'd6: begin n = 8'((int'(mq) + 1) % 256); mco = (mq == 8'd255); end
        3'd7: begin n = 8'((int'(mq) + 255) % 256); mco = (mq == 8'd0); end
`endif
        default: n = mq;
      endcase
    end
    mq = n;
  endtask

  initial begin
    // c, s, e, mode, d, sil, sir, exp
    tbl[0]  = '{0,0,1,3'd1,8'hC3,0,0,8'hC3};
    tbl[1]  = '{0,0,0,3'd1,8'h00,0,0,8'hC3};  // e=0 holds
    tbl[2]  = '{1,1,0,3'd0,8'h00,0,0,8'h00};  // clear beats set
    tbl[3]  = '{0,1,0,3'd0,8'h00,0,0,8'hFF};  // set ignores e
    tbl[4]  = '{0,0,1,3'd1,8'h81,0,0,8'h81};
    tbl[5]  = '{0,0,1,3'd2,8'h00,0,0,8'h02};
    tbl[6]  = '{0,0,1,3'd3,8'h00,0,1,8'h81};
    tbl[7]  = '{0,0,1,3'd4,8'h00,0,0,8'h03};
    tbl[8]  = '{0,0,1,3'd5,8'h00,0,0,8'h81};
    tbl[9]  = '{0,0,1,3'd5,8'h00,0,0,8'hC0};
    tbl[10] = '{0,0,1,3'd5,8'h00,0,0,8'h60};
    tbl[11] = '{0,0,1,3'd0,8'hFF,1,1,8'h60};  // hold mode
`ifdef SHREG_RS_COUNT_EN
    tbl[12] = '{0,0,1,3'd6,8'h00,0,0,8'h61};
    tbl[13] = '{0,0,1,3'd7,8'h00,0,0,8'h60};
`else
    tbl[12] = '{0,0,1,3'd6,8'h00,0,0,8'h60};
    tbl[13] = '{0,0,1,3'd7,8'h00,0,0,8'h60};
`endif
    tbl[14] = '{1,0,1,3'd1,8'h77,0,0,8'h00};  // clear beats load

    // reset state
    r = 1'b1;
    #2;
    chk("reset_q", q, 8'h00);
    chk("reset_som_sol", {6'd0, som, sol}, 8'h00);
`ifdef SHREG_RS_COUNT_EN
    chk("reset_co", {7'd0, co}, 8'h00);
`endif
    step();
    chk("reset_held_over_edge", q, 8'h00);
    r = 1'b0;

    // async reset between edges
    drive(0,0,1,3'd1,8'h5A,0,0);
    step();
    chk("load_5A", q, 8'h5A);
    drive(0,0,0,3'd0,8'h00,0,0);
    #1; r = 1'b1; #1;
    chk("async_reset_immediate", q, 8'h00);
    #1; r = 1'b0;

    // table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].c, tbl[i].s, tbl[i].e, tbl[i].mode, tbl[i].d, tbl[i].sil, tbl[i].sir);
      step();
      chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
      chk($sformatf("tbl%0d_som_sol", i), {6'd0, som, sol},
          {6'd0, tbl[i].exp_q[7], tbl[i].exp_q[0]});
    end

    // serialise A5 out the low end
    begin
      logic [7:0] pat;
      pat = 8'hA5;
      drive(0,0,1,3'd1,8'hA5,0,0);
      step();
      drive(0,0,1,3'd3,8'h00,0,0);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("ser_sol%0d", i), {7'd0, sol}, {7'd0, pat[i]});
        step();
      end
      chk("ser_final", q, 8'h00);
    end

    // counting corner sequence
    drive(0,0,1,3'd1,8'hFF,0,0);
    step();
    drive(0,0,1,3'd6,8'h00,0,0);
    step();
`ifdef SHREG_RS_COUNT_EN
    chk("inc_wrap_q", q, 8'h00);
    chk("inc_wrap_co", {7'd0, co}, 8'h01);
    mode = 3'd7; step();
    chk("dec_wrap_q", q, 8'hFF);
    chk("dec_wrap_co", {7'd0, co}, 8'h01);
    mode = 3'd6; step();
    chk("inc_wrap2_q", q, 8'h00);
    chk("inc_wrap2_co", {7'd0, co}, 8'h01);
    step();
    chk("inc_q", q, 8'h01);
    chk("inc_co", {7'd0, co}, 8'h00);
    mode = 3'd6; d = 8'h00; e = 1'b0; step();
`else
    chk("mode110_hold", q, 8'hFF);
    mode = 3'd7; step();
    chk("mode111_hold", q, 8'hFF);
`endif

    // randomized against the reference model
    mq  = q;
`ifdef SHREG_RS_COUNT_EN
    mco = co;
`else
    mco = 1'b0;
`endif
    for (int i = 0; i < 400; i++) begin
      c    = ($urandom_range(0, 15) == 0);
      s    = ($urandom_range(0, 15) == 0);
      e    = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      sil  = 1'($urandom);
      sir  = 1'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        r = 1'b1; #1;
        mq = 8'h00; mco = 1'b0;
        chk("rnd_async_reset", q, mq);
        r = 1'b0;
      end
      model_edge();
      step();
      chk($sformatf("rnd%0d_q", i), q, mq);
      chk($sformatf("rnd%0d_som_sol", i), {6'd0, som, sol}, {6'd0, mq[7], mq[0]});
`ifdef SHREG_RS_COUNT_EN
      chk($sformatf("rnd%0d_co", i), {7'd0, co}, {7'd0, mco});
`endif
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
